// File: rtl/pong_pkg.sv
// Game-object defaults shared between ball_controller and draw_ball.
package pong_pkg;

    localparam int          BALL_SIZE  = 16;
    localparam logic [11:0] BALL_COLOR = 12'hFFF;

endpackage

// File: rtl/vga_pkg.sv
// 1024x768@60 VGA timing constants shared by the video pipeline stages.
package vga_pkg;

    localparam int H_ACTIVE     = 1024;
    localparam int H_SYNC_START = 1048;
    localparam int H_SYNC_END   = 1184;
    localparam int H_TOTAL      = 1344;

    localparam int V_ACTIVE     = 768;
    localparam int V_SYNC_START = 771;
    localparam int V_SYNC_END   = 777;
    localparam int V_TOTAL      = 806;

endpackage

// File: rtl/delay.sv
// Generic synchronous-reset shift-register delay of WIDTH bits by CLK_DEL cycles (CLK_DEL >= 1).
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_r [CLK_DEL];

    // Shift chain; every tap clears on reset so the output reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[CLK_DEL-1];

endmodule

// File: rtl/draw_ball.sv
// Overlays a filled round ball on the VGA pixel stream; position is latched once per frame
// at the start of vertical blanking, and all timing is delayed 2 cycles to match the colour path.
module draw_ball
    import vga_pkg::*;
    import pong_pkg::*;
#(
    parameter int          BALL_SIZE  = pong_pkg::BALL_SIZE,
    parameter logic [11:0] BALL_COLOR = pong_pkg::BALL_COLOR,
    parameter int          H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int          V_ACTIVE   = vga_pkg::V_ACTIVE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x_ball,
    input  logic [9:0]  y_ball,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int                 TIMING_W = 26;
    localparam logic signed [11:0] SIZE_S   = 12'(BALL_SIZE);
    localparam logic signed [7:0]  SIZE_M1  = 8'(BALL_SIZE - 1);
    localparam logic [15:0]        RADIUS_SQ = 16'(BALL_SIZE * BALL_SIZE);

    logic [TIMING_W-1:0] timing_in_s;
    logic [TIMING_W-1:0] timing_out_s;

    logic [9:0]  x_lat_r;
    logic [9:0]  y_lat_r;
    logic        pos_valid_r;
    logic        capture_s;

    logic signed [11:0] dx_s;
    logic signed [11:0] dy_s;
    logic signed [7:0]  cx_s;
    logic signed [7:0]  cy_s;
    logic               in_box_s;

    logic signed [7:0]  cx_r;
    logic signed [7:0]  cy_r;
    logic               in_box_r;
    logic [11:0]        rgb_d1_r;

    logic signed [15:0] cx_w_s;
    logic signed [15:0] cy_w_s;
    logic [15:0]        dist_sq_s;
    logic               in_ball_s;

    assign timing_in_s = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};

    delay #(
        .WIDTH   (TIMING_W),
        .CLK_DEL (2)
    ) u_timing_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (timing_in_s),
        .dout (timing_out_s)
    );

    assign {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} = timing_out_s;

    assign capture_s = (vcount_in == 11'(V_ACTIVE)) && (hcount_in == 11'd0);

    // Per-frame position latch, taken on the first pixel slot of vertical blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_lat_r     <= 10'd0;
            y_lat_r     <= 10'd0;
            pos_valid_r <= 1'b0;
        end else if (capture_s) begin
            x_lat_r     <= x_ball;
            y_lat_r     <= y_ball;
            pos_valid_r <= 1'b1;
        end
    end

    // Stage-1 geometry: signed box offsets so pixels left/above the box never match.
    always_comb begin
        dx_s     = $signed({1'b0, hcount_in}) - $signed({2'b00, x_lat_r});
        dy_s     = $signed({1'b0, vcount_in}) - $signed({2'b00, y_lat_r});
        cx_s     = $signed({dx_s[6:0], 1'b0}) - SIZE_M1;
        cy_s     = $signed({dy_s[6:0], 1'b0}) - SIZE_M1;
        in_box_s = (dx_s >= 12'sd0) && (dx_s < SIZE_S) &&
                   (dy_s >= 12'sd0) && (dy_s < SIZE_S) &&
                   (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 11'(V_ACTIVE)) &&
                   !hblnk_in && !vblnk_in && pos_valid_r;
    end

    // Stage-1 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx_r     <= 8'sd0;
            cy_r     <= 8'sd0;
            in_box_r <= 1'b0;
            rgb_d1_r <= 12'h000;
        end else begin
            cx_r     <= cx_s;
            cy_r     <= cy_s;
            in_box_r <= in_box_s;
            rgb_d1_r <= rgb_in;
        end
    end

    // Stage-2 circle test on doubled centred offsets: cx^2 + cy^2 <= size^2.
    always_comb begin
        cx_w_s    = 16'(cx_r);
        cy_w_s    = 16'(cy_r);
        dist_sq_s = $unsigned(cx_w_s * cx_w_s) + $unsigned(cy_w_s * cy_w_s);
        in_ball_s = in_box_r && (dist_sq_s <= RADIUS_SQ);
    end

    // Stage-2 colour mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out <= 12'h000;
        end else begin
            rgb_out <= in_ball_s ? BALL_COLOR : rgb_d1_r;
        end
    end

endmodule

// File: tb/tb_draw_ball.sv
// Scoreboard bench for draw_ball: per-pixel expected timing/colour queued at drive time, popped 2 cycles later.
module tb_draw_ball;

    localparam int          BS    = 16;
    localparam logic [11:0] COLOR = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x_ball, y_ball;
    logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_in, rgb_out;
    logic [25:0] tim_out;

    typedef struct {
        logic [25:0] tim;
        logic [11:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ball_cnt = 0;
    int   mx = 0, my = 0;
    bit   mvalid = 1'b0;
    bit   lm_en  = 1'b0;

    always #5 clk = ~clk;

    draw_ball #(.BALL_SIZE(BS), .BALL_COLOR(COLOR), .H_ACTIVE(1024), .V_ACTIVE(768)) dut (
        .clk(clk), .rst(rst), .x_ball(x_ball), .y_ball(y_ball),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
    );

    assign tim_out = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out};

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One pixel slot: drive inputs, queue the model's expectation, then score the output due now.
    task automatic cycle(input int h, input int v, input bit r);
        exp_t e;
        int   dx, dy;
        bit   hb, vb, hs, vs, inb;
        logic [11:0] pix;
        hb  = (h >= 1024);
        vb  = (v >= 768);
        hs  = (h >= 1048) && (h < 1184);
        vs  = (v >= 771) && (v < 777);
        pix = {h[3:0], v[3:0], 4'h5};
        rst = r; hcount_in = h[10:0]; vcount_in = v[10:0];
        hsync_in = hs; hblnk_in = hb; vsync_in = vs; vblnk_in = vb; rgb_in = pix;
        dx  = h - mx;
        dy  = v - my;
        inb = mvalid && !hb && !vb && dx >= 0 && dx < BS && dy >= 0 && dy < BS &&
              ((2*dx + 1 - BS) ** 2 + (2*dy + 1 - BS) ** 2 <= BS * BS);
        if (r) e = '{26'd0, 12'd0};
        else   e = '{{h[10:0], hs, hb, v[10:0], vs, vb}, inb ? COLOR : pix};
        if (r) begin
            mvalid = 1'b0; mx = 0; my = 0;
        end else if (v == 768 && h == 0) begin
            mvalid = 1'b1; mx = int'(x_ball); my = int'(y_ball);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            if (r) e = '{26'd0, 12'd0};
            check("timing", 38'(tim_out), 38'(e.tim));
            check("rgb", 38'(rgb_out), 38'(e.rgb));
            if (rgb_out == COLOR) ball_cnt++;
            if (!r && hcount_out == 11'd1047) check("hsync_pre", 38'(hsync_out), 38'd0);
            if (!r && hcount_out == 11'd1048) check("hsync_rise", 38'(hsync_out), 38'd1);
            if (lm_en) begin
                if (hcount_out == 11'd508 && vcount_out == 11'd308) check("lm_508_308", 38'(rgb_out), 38'(COLOR));
                if (hcount_out == 11'd507 && vcount_out == 11'd300) check("lm_507_300", 38'(rgb_out), 38'(COLOR));
                if (hcount_out == 11'd500 && vcount_out == 11'd307) check("lm_500_307", 38'(rgb_out), 38'(COLOR));
                if (hcount_out == 11'd500 && vcount_out == 11'd300) check("lm_500_300", 38'(rgb_out), 38'h4C5);
            end
        end
    endtask

    task automatic scan(input int x0, input int y0, input int w, input int h, input int exp_cnt, input string tag);
        ball_cnt = 0;
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                cycle(x, y, 1'b0);
            end
        end
        cycle(1100, 770, 1'b0);
        cycle(1101, 770, 1'b0);
        check(tag, 38'(ball_cnt), 38'(exp_cnt));
    endtask

    task automatic capture();
        cycle(0, 768, 1'b0);
    endtask

    initial begin
        x_ball = 10'd500; y_ball = 10'd300;
        for (int i = 0; i < 4; i++) cycle(1200, 790, 1'b1);

        // Frame 1 before any capture, then frame 2 with the ball.
        scan(496, 296, 24, 24, 0, "t1_no_ball_before_capture");
        capture();
        lm_en = 1'b1;
        scan(496, 296, 24, 24, 208, "t1_ball_count");
        lm_en = 1'b0;

        // hsync alignment around 1048.
        for (int x = 1044; x < 1052; x++) cycle(x, 300, 1'b0);

        // Mid-frame move is deferred to the next frame.
        x_ball = 10'd100;
        for (int x = 10; x < 20; x++) cycle(x, 200, 1'b0);
        scan(496, 296, 24, 24, 208, "t3_old_pos_kept");
        scan(96, 296, 24, 24, 0, "t3_new_pos_not_yet");
        capture();
        scan(96, 296, 24, 24, 208, "t3_new_pos");
        scan(496, 296, 24, 24, 0, "t3_old_pos_gone");

        // Change on the capture cycle is taken; one cycle later is not.
        x_ball = 10'd300;
        capture();
        x_ball = 10'd700;
        cycle(1, 768, 1'b0);
        scan(296, 296, 24, 24, 208, "t3_capture_edge_taken");
        scan(696, 296, 24, 24, 0, "t3_late_change_ignored");

        // Right/bottom clip: only one quadrant visible, no wrap.
        x_ball = 10'd1016; y_ball = 10'd760;
        capture();
        scan(1008, 752, 24, 24, 52, "t4_clip_quadrant");
        scan(0, 760, 8, 8, 0, "t4_no_wrap");

        // Origin and negative offsets.
        x_ball = 10'd0; y_ball = 10'd0;
        capture();
        scan(0, 0, 18, 18, 208, "t5_origin_ball");
        scan(1336, 0, 8, 16, 0, "t5_hblank_no_match");
        scan(0, 805, 16, 1, 0, "t5_dy_neg_no_match");

        // Reset mid-frame at line 400.
        for (int x = 100; x < 104; x++) cycle(x, 400, 1'b0);
        cycle(104, 400, 1'b1);
        cycle(105, 400, 1'b1);
        scan(0, 0, 18, 18, 0, "t6_absent_after_reset");
        capture();
        scan(0, 0, 18, 18, 208, "t6_back_after_capture");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
